lookup_cfg_writer: RTL

- Control-plane writer for one lookup_engine stage.
- Accepts configuration packets on an AXI-Stream slave and assembles full-width TCAM entries (key plus mask) from multi-beat packets.
- Drives the lookup engine's TCAM write channel (lookup_din*) and action RAM write channel (action_*) with single-cycle write strobes.
- Sits between the configuration packet filter and every lookup_engine instance; a header stage field selects the target stage.

---
 rtl/lookup_cfg_pkg.sv | 31 +++
 rtl/lookup_cfg_assembler.sv | 63 ++++++
 rtl/lookup_cfg_writer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lookup_cfg_pkg.sv
`default_nettype none
// ============================================================================
// lookup_cfg_pkg : shared constants and types for the lookup stage config writer
// Rev 1.0 - initial release
// ============================================================================
package lookup_cfg_pkg;

    localparam logic [7:0] OP_TCAM_WR = 8'h01;
    localparam logic [7:0] OP_ACT_WR  = 8'h02;

    localparam int HDR_OP_LSB    = 0;
    localparam int HDR_STAGE_LSB = 8;
    localparam int HDR_ADDR_LSB  = 12;
    localparam int HDR_ACT_LSB   = 16;

    typedef enum logic [2:0] {
        ST_HDR    = 3'd0,
        ST_KEY    = 3'd1,
        ST_MASK   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ACT    = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    // Number of stream beats that make up one key (or one mask).
    function automatic int calc_beats(input int entry_w, input int data_w);
        return entry_w / data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lookup_cfg_assembler.sv
`default_nettype none
// ============================================================================
// lookup_cfg_assembler : beat counter + shift register building one entry word
// Rev 1.0 - initial release
// ============================================================================
module lookup_cfg_assembler
    import lookup_cfg_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int ENTRY_WIDTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   shift_i,
    input  logic [DATA_WIDTH-1:0]  beat_i,
    output logic [ENTRY_WIDTH-1:0] word_o,
    output logic                   last_o
);

    localparam int BEATS = calc_beats(ENTRY_WIDTH, DATA_WIDTH);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ENTRY_WIDTH-1:0] word_q, word_d, shifted;

    // Beats arrive lowest bits first, so each new beat enters at the top.
    generate
        if (BEATS > 1) begin : g_multi
            assign shifted = {beat_i, word_q[ENTRY_WIDTH-1:DATA_WIDTH]};
        end else begin : g_single
            assign shifted = beat_i;
        end
    endgenerate

    assign last_o = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            word_d = shifted;
            cnt_d  = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    // Includes the beat being shifted this cycle so the closing beat is usable at once.
    assign word_o = word_d;

endmodule
`default_nettype wire

// File: rtl/lookup_cfg_writer.sv
`default_nettype none
// ============================================================================
// lookup_cfg_writer : AXIS config packets -> TCAM / action RAM write strobes
// Optional LOOKUP_CFG_ERR_CNT_EN builds the saturating malformed-packet counter.
// Rev 1.0 - initial release
// ============================================================================
module lookup_cfg_writer
    import lookup_cfg_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int ENTRY_WIDTH         = 1024,
    parameter int ACT_WIDTH           = 25,
    parameter int ADDR_WIDTH          = 4,
    parameter int STAGE               = 0
) (
    input  logic                           axis_clk,
    input  logic                           aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [ENTRY_WIDTH-1:0]         lookup_din,
    output logic [ENTRY_WIDTH-1:0]         lookup_din_mask,
    output logic [ADDR_WIDTH-1:0]          lookup_din_addr,
    output logic                           lookup_din_en,
    output logic [ACT_WIDTH-1:0]           action_data_in,
    output logic [ADDR_WIDTH-1:0]          action_addr,
    output logic                           action_en,
    output logic [15:0]                    cfg_err_cnt
);

    localparam logic [3:0] STAGE_ID = 4'(STAGE);

    state_t                   state_q, state_d;
    logic                     ready, accept;
    logic                     asm_clr, key_shift, mask_shift, key_last, mask_last;
    logic                     err_ev, ld_tcam, ld_act;
    logic [ENTRY_WIDTH-1:0]   key_word, mask_word;
    logic [ENTRY_WIDTH-1:0]   din_q, mask_q;
    logic [ADDR_WIDTH-1:0]    addr_q, din_addr_q, act_addr_q;
    logic [ACT_WIDTH-1:0]     act_data_q;

    logic [7:0]               hdr_op;
    logic [3:0]               hdr_stage;
    logic [ADDR_WIDTH-1:0]    hdr_addr;
    logic [ACT_WIDTH-1:0]     hdr_act;

    assign hdr_op    = s_axis_tdata[HDR_OP_LSB +: 8];
    assign hdr_stage = s_axis_tdata[HDR_STAGE_LSB +: 4];
    assign hdr_addr  = s_axis_tdata[HDR_ADDR_LSB +: ADDR_WIDTH];
    assign hdr_act   = s_axis_tdata[HDR_ACT_LSB +: ACT_WIDTH];

    assign ready  = (state_q == ST_HDR) || (state_q == ST_KEY) ||
                    (state_q == ST_MASK) || (state_q == ST_DRAIN);
    assign accept = s_axis_tvalid & ready;

    lookup_cfg_assembler #(
        .DATA_WIDTH  (C_S_AXIS_DATA_WIDTH),
        .ENTRY_WIDTH (ENTRY_WIDTH)
    ) u_key_asm (
        .clk     (axis_clk),
        .rst_n   (aresetn),
        .clr_i   (asm_clr),
        .shift_i (key_shift),
        .beat_i  (s_axis_tdata),
        .word_o  (key_word),
        .last_o  (key_last)
    );

    lookup_cfg_assembler #(
        .DATA_WIDTH  (C_S_AXIS_DATA_WIDTH),
        .ENTRY_WIDTH (ENTRY_WIDTH)
    ) u_mask_asm (
        .clk     (axis_clk),
        .rst_n   (aresetn),
        .clr_i   (asm_clr),
        .shift_i (mask_shift),
        .beat_i  (s_axis_tdata),
        .word_o  (mask_word),
        .last_o  (mask_last)
    );

    always_comb begin
        state_d    = state_q;
        asm_clr    = 1'b0;
        key_shift  = 1'b0;
        mask_shift = 1'b0;
        err_ev     = 1'b0;
        ld_tcam    = 1'b0;
        ld_act     = 1'b0;
        case (state_q)
            ST_HDR: begin
                asm_clr = 1'b1;
                if (accept) begin
                    // Packets for other stages are skipped silently, whatever their opcode.
                    if (hdr_stage != STAGE_ID) begin
                        state_d = s_axis_tlast ? ST_HDR : ST_DRAIN;
                    end else if (hdr_op == OP_TCAM_WR && !s_axis_tlast) begin
                        state_d = ST_KEY;
                    end else if (hdr_op == OP_ACT_WR && s_axis_tlast) begin
                        ld_act  = 1'b1;
                        state_d = ST_ACT;
                    end else begin
                        err_ev  = 1'b1;
                        state_d = s_axis_tlast ? ST_HDR : ST_DRAIN;
                    end
                end
            end
            ST_KEY: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        err_ev  = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        key_shift = 1'b1;
                        if (key_last) state_d = ST_MASK;
                    end
                end
            end
            ST_MASK: begin
                if (accept) begin
                    if (mask_last) begin
                        mask_shift = 1'b1;
                        if (s_axis_tlast) begin
                            ld_tcam = 1'b1;
                            state_d = ST_COMMIT;
                        end else begin
                            err_ev  = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        err_ev  = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        mask_shift = 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_HDR;
            ST_ACT:    state_d = ST_HDR;
            ST_DRAIN: begin
                if (accept && s_axis_tlast) state_d = ST_HDR;
            end
            default:   state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_HDR;
            addr_q     <= '0;
            din_q      <= '0;
            mask_q     <= '0;
            din_addr_q <= '0;
            act_data_q <= '0;
            act_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && state_q == ST_HDR) addr_q <= hdr_addr;
            if (ld_tcam) begin
                din_q      <= key_word;
                mask_q     <= mask_word;
                din_addr_q <= addr_q;
            end
            if (ld_act) begin
                act_data_q <= hdr_act;
                act_addr_q <= hdr_addr;
            end
        end
    end

    assign s_axis_tready   = ready & aresetn;
    assign lookup_din      = din_q;
    assign lookup_din_mask = mask_q;
    assign lookup_din_addr = din_addr_q;
    assign lookup_din_en   = (state_q == ST_COMMIT);
    assign action_data_in  = act_data_q;
    assign action_addr     = act_addr_q;
    assign action_en       = (state_q == ST_ACT);

`ifdef LOOKUP_CFG_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt_q <= '0;
        end else if (err_ev && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign cfg_err_cnt = err_cnt_q;
`else
    logic err_ev_unused;
    assign err_ev_unused = err_ev;
    assign cfg_err_cnt   = '0;
`endif

endmodule
`default_nettype wire
